// File: rtl/in_mem_pingpong.sv
// Ping-pong input feature-map memory: DMA fills one bank while the selected read client drains the other.
// Optional IN_MEM_OUT_REG_EN adds an output pipeline stage (read latency 2 instead of 1).
module in_mem_pingpong #(
  parameter int AXI_HP_BIT = 64,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_RD     = 3,
  parameter int OP_WIDTH   = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [OP_WIDTH-1:0]                 OPCODE,
  input  logic                                wr_en,
  input  logic [ADDR_WIDTH:0]                 wr_addr,
  input  logic [AXI_HP_BIT-1:0]               wr_data,
  input  logic                                wr_last,
  output logic                                wr_ready,
  input  logic [NUM_RD-1:0]                   rd_en,
  input  logic [NUM_RD*(ADDR_WIDTH+1)-1:0]    rd_addr,
  input  logic                                rd_release,
  output logic                                rd_ready,
  output logic [AXI_HP_BIT-1:0]               rd_data,
  output logic                                rd_valid,
  output logic [1:0]                          bank_full,
  output logic                                wr_bank,
  output logic                                rd_bank,
  output logic                                wr_ovf,
  output logic                                rd_udf
);

  localparam int AW = ADDR_WIDTH + 1;

  // Bank index is the MSB of the RAM address.
  logic [AXI_HP_BIT-1:0] mem [0:(2**(AW+1))-1];

  logic [1:0]            bank_full_reg, bank_full_next;
  logic                  wr_bank_reg, rd_bank_reg;
  logic                  wr_ovf_reg, rd_udf_reg;
  logic                  rd_valid_reg;
  logic [AXI_HP_BIT-1:0] rd_data_reg;

  logic [AW-1:0]         addr_slice [NUM_RD];
  logic [NUM_RD-1:0]     hit;
  logic                  sel_en;
  logic [AW-1:0]         sel_addr;

  logic                  wr_fire, wr_done, rd_fire, rel_fire;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_client
    assign addr_slice[gi] = rd_addr[gi*AW +: AW];
    assign hit[gi]        = rd_en[gi] && (OPCODE == OP_WIDTH'(gi));
  end

  // Opcodes with no matching client leave strobe and address at zero.
  always_comb begin
    sel_en   = |hit;
    sel_addr = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (OPCODE == OP_WIDTH'(k)) begin
        sel_addr = addr_slice[k];
      end
    end
  end

  assign wr_ready = !bank_full_reg[wr_bank_reg];
  assign rd_ready = bank_full_reg[rd_bank_reg];

  assign wr_fire  = wr_en && wr_ready;
  assign wr_done  = wr_fire && wr_last;
  assign rd_fire  = sel_en && rd_ready;
  assign rel_fire = rd_release && rd_ready;

  // A completing write and a release always hit different banks, so both can apply.
  always_comb begin
    bank_full_next = bank_full_reg;
    if (wr_done) begin
      bank_full_next[wr_bank_reg] = 1'b1;
    end
    if (rel_fire) begin
      bank_full_next[rd_bank_reg] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_full_reg <= 2'b00;
      wr_bank_reg   <= 1'b0;
      rd_bank_reg   <= 1'b0;
      wr_ovf_reg    <= 1'b0;
      rd_udf_reg    <= 1'b0;
      rd_valid_reg  <= 1'b0;
    end else begin
      bank_full_reg <= bank_full_next;
      if (wr_done) begin
        wr_bank_reg <= ~wr_bank_reg;
      end
      if (rel_fire) begin
        rd_bank_reg <= ~rd_bank_reg;
      end
      if (wr_en && !wr_ready) begin
        wr_ovf_reg <= 1'b1;
      end
      if (sel_en && !rd_ready) begin
        rd_udf_reg <= 1'b1;
      end
      rd_valid_reg <= rd_fire;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) begin
      mem[{wr_bank_reg, wr_addr}] <= wr_data;
    end
  end

  // Read uses the pre-release bank, so a same-cycle release never loses the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (rd_fire) begin
      rd_data_reg <= mem[{rd_bank_reg, sel_addr}];
    end
  end

`ifdef IN_MEM_OUT_REG_EN
  logic [AXI_HP_BIT-1:0] out_data_reg;
  logic                  out_valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= rd_valid_reg;
      if (rd_valid_reg) begin
        out_data_reg <= rd_data_reg;
      end
    end
  end

  assign rd_data  = out_data_reg;
  assign rd_valid = out_valid_reg;
`else
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
`endif

  assign bank_full = bank_full_reg;
  assign wr_bank   = wr_bank_reg;
  assign rd_bank   = rd_bank_reg;
  assign wr_ovf    = wr_ovf_reg;
  assign rd_udf    = rd_udf_reg;

endmodule

// File: tb/tb_in_mem_pingpong.sv
// Bench for in_mem_pingpong: directed test-plan steps followed by random traffic against a bank-level model.
module tb_in_mem_pingpong;
  localparam int W   = 64;
  localparam int AW  = 15;
  localparam int NR  = 3;
  localparam int OPW = 3;
`ifdef IN_MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic [OPW-1:0]    OPCODE;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic              rd_release;
  logic              rd_ready;
  logic [W-1:0]      rd_data;
  logic              rd_valid;
  logic [1:0]        bank_full;
  logic              wr_bank;
  logic              rd_bank;
  logic              wr_ovf;
  logic              rd_udf;

  in_mem_pingpong dut (
    .clk(clk), .rst_n(rst_n), .OPCODE(OPCODE),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .bank_full(bank_full),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .wr_ovf(wr_ovf), .rd_udf(rd_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: bank ownership flags plus a list of reads in flight with their return cycle.
  bit [1:0]    m_full;
  bit          m_wb, m_rb, m_ovf, m_udf;
  logic [W-1:0] m_held;
  logic [W-1:0] mm [int];
  typedef struct { int due; logic [W-1:0] data; } pend_t;
  pend_t pend [$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit wready, rready, sel;
    logic [AW-1:0] sad;
    int op, key;
    if (!rst_n) begin
      m_full = 2'b00; m_wb = 0; m_rb = 0; m_ovf = 0; m_udf = 0;
      m_held = '0;
      pend.delete();
    end else begin
      wready = !m_full[m_wb];
      rready = m_full[m_rb];
      op  = int'(OPCODE);
      sel = 0;
      sad = '0;
      if (op < NR) begin
        sel = rd_en[op];
        sad = rd_addr[op*AW +: AW];
      end
      if (sel) begin
        if (rready) begin
          key = int'({m_rb, sad});
          pend.push_back('{due: cyc + LAT, data: mm[key]});
        end else begin
          m_udf = 1;
        end
      end
      if (wr_en) begin
        if (wready) begin
          key = int'({m_wb, wr_addr});
          mm[key] = wr_data;
          if (wr_last) begin
            m_full[m_wb] = 1;
            m_wb = ~m_wb;
          end
        end else begin
          m_ovf = 1;
        end
      end
      if (rd_release && rready) begin
        m_full[m_rb] = 0;
        m_rb = ~m_rb;
      end
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1;
      m_held = pend[0].data;
      pend.pop_front();
      $display("cycle %0d: read return data=%h", cyc, m_held);
    end
    chk("rd_valid",  rd_valid,  ev);
    chk("rd_data",   rd_data,   m_held);
    chk("bank_full", bank_full, m_full);
    chk("wr_bank",   wr_bank,   m_wb);
    chk("rd_bank",   rd_bank,   m_rb);
    chk("wr_ready",  wr_ready,  !m_full[m_wb]);
    chk("rd_ready",  rd_ready,  m_full[m_rb]);
    chk("wr_ovf",    wr_ovf,    m_ovf);
    chk("rd_udf",    rd_udf,    m_udf);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_last = 0; rd_en = '0; rd_release = 0;
  endtask

  task automatic do_wr(input int addr, input logic [W-1:0] data, input bit last);
    wr_en = 1; wr_addr = AW'(addr); wr_data = data; wr_last = last;
    tick();
    idle_inputs();
  endtask

  task automatic set_rd(input int op, input logic [NR-1:0] en, input int addr);
    OPCODE = OPW'(op);
    rd_en  = en;
    for (int k = 0; k < NR; k++) begin
      rd_addr[k*AW +: AW] = (k == op) ? AW'(addr) : AW'($urandom_range(0, 3));
    end
  endtask

  task automatic do_rd(input int op, input logic [NR-1:0] en, input int addr);
    set_rd(op, en, addr);
    tick();
    idle_inputs();
  endtask

  task automatic do_rel();
    rd_release = 1;
    tick();
    idle_inputs();
  endtask

  initial begin
    int wptr;
    bit accept;
    rst_n = 0; OPCODE = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    idle_inputs();
    tick(); tick();
    rst_n = 1;
    tick();
    chk("idle_bank_full", bank_full, 64'd0);
    chk("idle_wr_ready", wr_ready, 64'd1);
    chk("idle_rd_ready", rd_ready, 64'd0);

    // Fill bank 0 and read addr 2 through client 1.
    for (int i = 0; i < 4; i++) do_wr(i, 64'h11 * (i + 1), i == 3);
    chk("fill0_bank_full", bank_full, 64'd1);
    chk("fill0_wr_bank", wr_bank, 64'd1);
    chk("fill0_rd_ready", rd_ready, 64'd1);
    do_rd(1, 3'b010, 2);
    repeat (LAT - 1) tick();
    chk("rd33_valid", rd_valid, 64'd1);
    chk("rd33_data", rd_data, 64'h33);

    // Both banks full: overflow, then read and release.
    do_wr(0, 64'hAA, 1);
    chk("both_full_wr_ready", wr_ready, 64'd0);
    do_wr(5, 64'hDEAD, 0);
    chk("ovf_flag", wr_ovf, 64'd1);
    do_rd(0, 3'b001, 0);
    repeat (LAT - 1) tick();
    chk("rd11_data", rd_data, 64'h11);
    do_rel();
    chk("rel_rd_bank", rd_bank, 64'd1);
    chk("rel_bank_full", bank_full, 64'd2);
    do_rd(2, 3'b100, 0);
    repeat (LAT - 1) tick();
    chk("rdAA_data", rd_data, 64'hAA);

    // Unselected client and out-of-range opcode.
    do_rd(2, 3'b001, 0);
    repeat (LAT) tick();
    chk("op2_no_read", rd_valid, 64'd0);
    do_rd(5, 3'b111, 0);
    repeat (LAT) tick();
    chk("op5_no_read", rd_valid, 64'd0);

    // Empty banks: underflow, ignored release.
    do_rel();
    chk("empty_bank_full", bank_full, 64'd0);
    do_rd(0, 3'b001, 0);
    chk("udf_flag", rd_udf, 64'd1);
    do_rel();
    chk("empty_rel_rd_bank", rd_bank, 64'd0);

    // Simultaneous bank completion and release.
    do_wr(0, 64'h55, 1);
    wr_en = 1; wr_addr = '0; wr_data = 64'h66; wr_last = 1; rd_release = 1;
    tick();
    idle_inputs();
    chk("simul_bank_full", bank_full, 64'd2);
    chk("simul_wr_bank", wr_bank, 64'd0);
    chk("simul_rd_bank", rd_bank, 64'd1);

    // Read and release in the same cycle still returns data.
    set_rd(0, 3'b001, 0);
    rd_release = 1;
    tick();
    idle_inputs();
    repeat (LAT - 1) tick();
    chk("rd_rel_same_data", rd_data, 64'h66);

    // Reset mid-fill.
    do_wr(1, 64'h77, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rst_bank_full", bank_full, 64'd0);
    chk("rst_ptrs", {wr_bank, rd_bank}, 64'd0);
    chk("rst_flags", {wr_ovf, rd_udf}, 64'd0);
    do_wr(0, 64'h99, 1);
    chk("after_rst_fill_bank0", bank_full, 64'd1);

    // Random traffic: fills write addresses 0..15, reads stay in that range.
    rst_n = 0;
    tick();
    rst_n = 1;
    wptr = 0;
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      if ($urandom_range(0, 99) < 40) begin
        wr_en   = 1;
        wr_addr = AW'(wptr);
        wr_data = {$urandom, $urandom};
        wr_last = (wptr == 15);
      end
      OPCODE = OPW'($urandom_range(0, 7));
      rd_en  = NR'($urandom_range(0, 7));
      for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
      rd_release = ($urandom_range(0, 99) < 8);
      rst_n = ($urandom_range(0, 999) != 0);
      accept = rst_n && wr_en && !m_full[m_wb];
      tick();
      if (!rst_n) wptr = 0;
      else if (accept) wptr = (wptr + 1) % 16;
    end
    rst_n = 1;
    idle_inputs();
    repeat (LAT + 1) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/in_mem_pingpong.md
Name: in_mem_pingpong

Overview:
- Double-buffered (ping-pong) input feature-map memory. AXI-HP write side fills one bank while the compute engines read the other bank.
- Generalises the single-bank input memory:
  - parametrised number of read clients, selected by OPCODE;
  - per-bank full/empty tracking with explicit hand-over;
  - registered read data with a valid strobe;
  - sticky error flags.
- Sits between the AXI DMA write path and the conv / conv-1x1 / maxpool address generators.

Parameters:
- AXI_HP_BIT, 64, data word width (write and read).
- ADDR_WIDTH, 14, address ports are ADDR_WIDTH+1 bits; each bank holds 2^(ADDR_WIDTH+1) words.
- NUM_RD, 3, number of read clients (1..8).
- OP_WIDTH, 3, OPCODE width; must satisfy 2^OP_WIDTH >= NUM_RD.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- OPCODE  in  OP_WIDTH  read-client select; value k<NUM_RD selects client k.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH+1  write address within current write bank.
- wr_data  in  AXI_HP_BIT  write data.
- wr_last  in  1  qualifies wr_en; final beat of a bank fill.
- wr_ready  out  1  current write bank not full.
- rd_en  in  NUM_RD  per-client read strobe, bit k = client k.
- rd_addr  in  NUM_RD*(ADDR_WIDTH+1)  client k address at slice [k*(ADDR_WIDTH+1) +: ADDR_WIDTH+1].
- rd_release  in  1  pulse: reader done with current read bank.
- rd_ready  out  1  current read bank full.
- rd_data  out  AXI_HP_BIT  read data.
- rd_valid  out  1  rd_data valid this cycle.
- bank_full  out  2  per-bank full flags.
- wr_bank  out  1  bank index currently being written.
- rd_bank  out  1  bank index currently being read.
- wr_ovf  out  1  sticky: write attempted while !wr_ready.
- rd_udf  out  1  sticky: read attempted while !rd_ready.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - bank_full=2'b00, wr_bank=0, rd_bank=0;
  - rd_valid=0, rd_data=0;
  - wr_ovf=0, rd_udf=0.
  - Memory contents are not reset.
  - Reset asserted mid-fill or mid-read discards all bank state; the next fill starts in bank 0.
- wr_ready = !bank_full[wr_bank] (combinational). rd_ready = bank_full[rd_bank] (combinational).
- Write path:
  - wr_en && wr_ready: writes wr_data to bank wr_bank at wr_addr.
  - If wr_last is also set: bank_full[wr_bank] <= 1 and wr_bank toggles at the same edge.
  - wr_en && !wr_ready: write dropped, wr_ovf <= 1, no state change.
- Read client select (combinational):
  - OPCODE=k<NUM_RD: selected strobe = rd_en[k], address = slice k.
  - OPCODE>=NUM_RD: selected strobe = 0, address = 0.
  - Unselected clients are ignored.
- Read path:
  - Selected strobe && rd_ready: bank rd_bank is read at the selected address. rd_data is registered; rd_valid=1 exactly 1 cycle later (latency 1).
  - Selected strobe && !rd_ready: no read, rd_valid=0 next cycle, rd_udf <= 1.
  - rd_data holds its last value while rd_valid=0.
- Release:
  - rd_release && rd_ready: bank_full[rd_bank] <= 0 and rd_bank toggles.
  - rd_release && !rd_ready: ignored, no flag.
  - A read and a release in the same cycle: the read uses the old rd_bank and its data still returns next cycle; the release then takes effect.
- Simultaneous events:
  - wr_last completing one bank and rd_release of the other bank in the same cycle: both updates apply.
  - Write and read never target the same bank, because writes go only to non-full banks and reads only to full banks.
  - Both banks full: wr_ready=0 until a release.
  - Both banks empty: rd_ready=0.
- Address wrap: none; addresses are bank-local, and out-of-range addresses cannot exist given the port width.
- Storage: two inferred simple-dual-port RAMs, or one RAM with the bank bit as address MSB.

Optional Feature:
- Macro: IN_MEM_OUT_REG_EN.
- Defined:
  - adds an output pipeline register after the RAM read;
  - read latency 2, rd_valid 2 cycles after the accepted read;
  - both pipeline stages reset to 0.
  - Release/read same-cycle semantics are unchanged: data for accepted reads always returns.
- Undefined: latency 1 as above.

Test Plan:
- Reset then idle -> bank_full=00, wr_ready=1, rd_ready=0, rd_valid=0, wr_ovf=rd_udf=0.
- Fill bank0: addr 0..3 with data 0x11..0x44, wr_last on addr 3 -> bank_full=01, wr_bank=1, rd_ready=1. Then OPCODE=1, client1 reads addr 2 -> rd_valid one cycle later, rd_data=0x33 (two cycles later with IN_MEM_OUT_REG_EN).
- Fill both banks (bank1 addr0=0xAA, last) -> wr_ready=0. A further wr_en sets wr_ovf=1, and reading bank0 addr0 still returns 0x11. Then rd_release -> rd_bank=1, bank_full=10, wr_ready=1, and a read of addr0 returns 0xAA.
- OPCODE=2 with rd_en=3'b001 (client0 only) -> no read, rd_valid stays 0. OPCODE=5 with any rd_en -> no read.
- Read with both banks empty -> rd_udf=1, rd_valid=0. rd_release while empty -> no state change.
- Same cycle: wr_last completes bank1 and rd_release frees bank0 -> bank_full=10, wr_bank=0, rd_bank=1. Then assert rst_n=0 mid-fill -> all flags and pointers return to reset values.
